// File: rtl/hazard_ctrl_if.sv
// ID-side hazard controller bundle: decoded ID fields, flush/hold in; stall, bubble,
// forward selects and stall counter out. master = pipeline side, slave = controller.
interface hazard_ctrl_if #(
  parameter int HAZ_DEPTH = 2,
  parameter int CNT_W     = 16
);
  localparam int FSEL_W = $clog2(HAZ_DEPTH + 1);

  logic              id_valid;
  logic [4:0]        id_rs1;
  logic [4:0]        id_rs2;
  logic              id_rs1_used;
  logic              id_rs2_used;
  logic [4:0]        id_rd;
  logic              id_we;
  logic              id_is_load;
  logic              flush;
  logic              hold;
  logic              stall_if;
  logic              stall_id;
  logic              bubble_ex;
  logic [FSEL_W-1:0] fwd_rs1;
  logic [FSEL_W-1:0] fwd_rs2;
  logic [CNT_W-1:0]  stall_cnt;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd, id_we, id_is_load,
           flush, hold,
    input  stall_if, stall_id, bubble_ex, fwd_rs1, fwd_rs2, stall_cnt
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd, id_we, id_is_load,
           flush, hold,
    output stall_if, stall_id, bubble_ex, fwd_rs1, fwd_rs2, stall_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// miniRV hazard/forwarding controller: tracks in-flight destination tags, stalls IF/ID,
// injects EX bubbles, counts stall cycles. Define HAZARD_FWD_EN for forwarding selects.

module hazard_tag_match (
  input  logic       tag_v,
  input  logic [4:0] tag_rd,
  input  logic [4:0] rs1,
  input  logic       rs1_used,
  input  logic [4:0] rs2,
  input  logic       rs2_used,
  output logic       m1,
  output logic       m2
);
  assign m1 = tag_v & rs1_used & (rs1 != 5'd0) & (tag_rd == rs1);
  assign m2 = tag_v & rs2_used & (rs2 != 5'd0) & (tag_rd == rs2);
endmodule

module hazard_ctrl #(
  parameter int HAZ_DEPTH = 2,
  parameter int CNT_W     = 16
) (
  input logic          clk,
  input logic          rst,
  hazard_ctrl_if.slave bus
);
  localparam int FSEL_W = $clog2(HAZ_DEPTH + 1);

  typedef struct packed {
    logic       v;
    logic [4:0] rd;
    logic       ld;
  } tag_t;

  tag_t [HAZ_DEPTH-1:0] tags;
  logic [HAZ_DEPTH-1:0] m1, m2;
  logic                 flush_pend;
  logic                 hz_raw, hz, fe, issue;
  logic [CNT_W-1:0]     cnt_q;
  logic [FSEL_W-1:0]    fwd1, fwd2;
  logic                 unused_ld;

  for (genvar g = 0; g < HAZ_DEPTH; g++) begin : g_stage
    hazard_tag_match u_match (
      .tag_v    (tags[g].v),
      .tag_rd   (tags[g].rd),
      .rs1      (bus.id_rs1),
      .rs1_used (bus.id_rs1_used),
      .rs2      (bus.id_rs2),
      .rs2_used (bus.id_rs2_used),
      .m1       (m1[g]),
      .m2       (m2[g])
    );
  end

`ifdef HAZARD_FWD_EN
  // Only a load still in EX cannot be forwarded; everything else is bypassed.
  assign hz_raw = (m1[0] | m2[0]) & tags[0].ld;

  // Scan oldest to youngest so the youngest producer overwrites last.
  always_comb begin
    fwd1 = '0;
    fwd2 = '0;
    for (int k = HAZ_DEPTH - 1; k >= 0; k--) begin
      if (m1[k]) fwd1 = FSEL_W'(k + 1);
      if (m2[k]) fwd2 = FSEL_W'(k + 1);
    end
  end
`else
  assign hz_raw = |{m1, m2};
  assign fwd1   = '0;
  assign fwd2   = '0;
`endif

  always_comb begin
    unused_ld = 1'b0;
    for (int k = 0; k < HAZ_DEPTH; k++) unused_ld = unused_ld ^ tags[k].ld;
  end

  assign hz    = bus.id_valid & hz_raw;
  assign fe    = (bus.flush | flush_pend) & ~bus.hold;
  assign issue = bus.id_valid & ~hz & ~fe & ~bus.hold;

  // Flush wins over the hazard stall so the fetch redirect is not blocked.
  assign bus.stall_if  = bus.hold | (hz & ~fe);
  assign bus.stall_id  = bus.hold | (hz & ~fe);
  assign bus.bubble_ex = ~bus.hold & (fe | hz);
  assign bus.fwd_rs1   = fwd1;
  assign bus.fwd_rs2   = fwd2;
  assign bus.stall_cnt = cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      tags       <= '0;
      flush_pend <= 1'b0;
      cnt_q      <= '0;
    end else if (bus.hold) begin
      // Pipeline frozen: remember a flush that arrived during the freeze.
      flush_pend <= flush_pend | bus.flush;
    end else begin
      flush_pend <= 1'b0;
      for (int k = HAZ_DEPTH - 1; k > 0; k--) tags[k] <= tags[k-1];
      if (issue && bus.id_we && bus.id_rd != 5'd0)
        tags[0] <= '{v: 1'b1, rd: bus.id_rd, ld: bus.id_is_load};
      else
        tags[0] <= '0;
      if (hz && !fe && cnt_q != {CNT_W{1'b1}})
        cnt_q <= cnt_q + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios plus random traffic against a producer-list
// model; a second instance with a 2-bit counter exercises saturation.
module tb_hazard_ctrl;
  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hazard_ctrl_if #(.HAZ_DEPTH(DEPTH), .CNT_W(16)) bus ();
  hazard_ctrl_if #(.HAZ_DEPTH(DEPTH), .CNT_W(2))  bus_s ();

  assign bus_s.id_valid    = bus.id_valid;
  assign bus_s.id_rs1      = bus.id_rs1;
  assign bus_s.id_rs2      = bus.id_rs2;
  assign bus_s.id_rs1_used = bus.id_rs1_used;
  assign bus_s.id_rs2_used = bus.id_rs2_used;
  assign bus_s.id_rd       = bus.id_rd;
  assign bus_s.id_we       = bus.id_we;
  assign bus_s.id_is_load  = bus.id_is_load;
  assign bus_s.flush       = bus.flush;
  assign bus_s.hold        = bus.hold;

  hazard_ctrl #(.HAZ_DEPTH(DEPTH), .CNT_W(16)) dut   (.clk(clk), .rst(rst), .bus(bus));
  hazard_ctrl #(.HAZ_DEPTH(DEPTH), .CNT_W(2))  dut_s (.clk(clk), .rst(rst), .bus(bus_s));

  int n_vec = 0;
  int n_err = 0;

  // Model: list of issued writers stamped with the advance-edge count at which they issued.
  typedef struct {
    logic [4:0] rd;
    bit         ld;
    int         ep;
  } prod_t;
  prod_t prod[$];
  int    ep_now = 0;
  bit    m_pend = 0;
  int    m_cnt  = 0;
  logic  e_stall, e_bubble, e_hz, e_fe, e_issue;
  logic [1:0] e_fwd1, e_fwd2;

  function automatic int youngest(input logic [4:0] rs, input logic used);
    int best = -1;
    if (!used || rs == 5'd0) return -1;
    foreach (prod[i]) begin
      int age = ep_now - prod[i].ep;
      if (prod[i].rd == rs && age < DEPTH && (best < 0 || age < best)) best = age;
    end
    return best;
  endfunction

  function automatic bit load_in_ex();
    foreach (prod[i]) if (prod[i].ep == ep_now && prod[i].ld) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void model_eval();
    int k1, k2;
    k1 = youngest(bus.id_rs1, bus.id_rs1_used);
    k2 = youngest(bus.id_rs2, bus.id_rs2_used);
`ifdef HAZARD_FWD_EN
    e_hz   = bus.id_valid && (k1 == 0 || k2 == 0) && load_in_ex();
    e_fwd1 = (k1 < 0) ? 2'd0 : 2'(k1 + 1);
    e_fwd2 = (k2 < 0) ? 2'd0 : 2'(k2 + 1);
`else
    e_hz   = bus.id_valid && (k1 >= 0 || k2 >= 0);
    e_fwd1 = 2'd0;
    e_fwd2 = 2'd0;
`endif
    e_fe     = (bus.flush || m_pend) && !bus.hold;
    e_stall  = bus.hold || (e_hz && !e_fe);
    e_bubble = !bus.hold && (e_fe || e_hz);
    e_issue  = bus.id_valid && !e_hz && !e_fe && !bus.hold;
  endfunction

  function automatic void model_update();
    prod_t p;
    if (rst) begin
      prod.delete();
      ep_now = 0; m_pend = 0; m_cnt = 0;
    end else if (bus.hold) begin
      m_pend = m_pend | bus.flush;
    end else begin
      m_pend = 0;
      if (e_hz && !e_fe) m_cnt++;
      ep_now++;
      if (e_issue && bus.id_we && bus.id_rd != 5'd0) begin
        p.rd = bus.id_rd; p.ld = bus.id_is_load; p.ep = ep_now;
        prod.push_back(p);
      end
      while (prod.size() > 0 && ep_now - prod[0].ep >= DEPTH) void'(prod.pop_front());
    end
  endfunction

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic apply(input logic v, input logic [4:0] r1, input logic u1, input logic [4:0] r2,
                       input logic u2, input logic [4:0] rd, input logic we, input logic ld,
                       input logic fl, input logic hd);
    bus.id_valid = v;  bus.id_rs1 = r1; bus.id_rs1_used = u1; bus.id_rs2 = r2;
    bus.id_rs2_used = u2; bus.id_rd = rd; bus.id_we = we; bus.id_is_load = ld;
    bus.flush = fl; bus.hold = hd;
    model_eval();
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
    model_eval();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    rst = 1'b0;
    model_eval();
  endtask

  // Advance until the model says the ID instruction issued; a missed bound is a failure.
  task automatic run_until_issue(input string tag);
    bit done = 0;
    for (int i = 0; i < 8 && !done; i++) begin
      done = e_issue;
      tick();
    end
    if (!done) begin n_err++; $display("FAIL %s issue_timeout got stuck want issue within 8", tag); end
    n_vec++;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    if ({bus.stall_if, bus.stall_id, bus.bubble_ex} !== 3'b000) begin
      n_err++; $display("FAIL reset ctrl got %b want 000", {bus.stall_if, bus.stall_id, bus.bubble_ex}); end
    n_vec++;
    if ({bus.fwd_rs1, bus.fwd_rs2} !== 4'd0) begin
      n_err++; $display("FAIL reset fwd got %0d/%0d want 0/0", bus.fwd_rs1, bus.fwd_rs2); end
    n_vec++;
    if (bus.stall_cnt !== 16'd0) begin n_err++; $display("FAIL reset cnt got %0d want 0", bus.stall_cnt); end
    n_vec++;
  endtask

  task automatic test_raw_stall();
    int nstall = 0;
    bit was;
    do_reset();
    apply(1, 0, 0, 0, 0, 5'd5, 1, 0, 0, 0);
    tick();
    apply(1, 5'd5, 1, 5'd0, 0, 5'd7, 1, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.stall_id !== e_stall || bus.bubble_ex !== e_bubble) begin
        n_err++; $display("FAIL raw cyc%0d stall/bubble got %b%b want %b%b", i, bus.stall_id, bus.bubble_ex, e_stall, e_bubble); end
      n_vec++;
      if (bus.stall_id) nstall++;
      was = e_issue;
      tick();
      if (was) break;
    end
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
`ifdef HAZARD_FWD_EN
    if (nstall != 0 || bus.stall_cnt !== 16'd0) begin
      n_err++; $display("FAIL raw stalls=%0d cnt=%0d want 0/0", nstall, bus.stall_cnt); end
`else
    if (nstall != 2 || bus.stall_cnt !== 16'd2) begin
      n_err++; $display("FAIL raw stalls=%0d cnt=%0d want 2/2", nstall, bus.stall_cnt); end
`endif
    n_vec++;
  endtask

  task automatic test_forwarding();
    do_reset();
    apply(1, 0, 0, 0, 0, 5'd5, 1, 0, 0, 0); tick();
    apply(1, 0, 0, 0, 0, 5'd6, 1, 0, 0, 0); tick();
    apply(1, 5'd5, 1, 5'd6, 1, 5'd0, 0, 0, 0, 0);
    @(negedge clk);
`ifdef HAZARD_FWD_EN
    if (bus.stall_id !== 1'b0 || bus.fwd_rs1 !== 2'd2 || bus.fwd_rs2 !== 2'd1) begin
      n_err++; $display("FAIL fwd_two stall=%b fwd=%0d/%0d want 0 2/1", bus.stall_id, bus.fwd_rs1, bus.fwd_rs2); end
`else
    if (bus.stall_id !== 1'b1 || bus.fwd_rs1 !== 2'd0 || bus.fwd_rs2 !== 2'd0) begin
      n_err++; $display("FAIL fwd_two stall=%b fwd=%0d/%0d want 1 0/0", bus.stall_id, bus.fwd_rs1, bus.fwd_rs2); end
`endif
    n_vec++;
    run_until_issue("fwd_two");
    apply(1, 0, 0, 0, 0, 5'd7, 1, 0, 0, 0); tick();
    apply(1, 0, 0, 0, 0, 5'd7, 1, 0, 0, 0); tick();
    apply(1, 5'd7, 1, 5'd0, 0, 5'd0, 0, 0, 0, 0);
    @(negedge clk);
    if (bus.fwd_rs1 !== e_fwd1 || bus.stall_id !== e_stall) begin
      n_err++; $display("FAIL fwd_young fwd=%0d stall=%b want %0d %b", bus.fwd_rs1, bus.stall_id, e_fwd1, e_stall); end
    n_vec++;
`ifdef HAZARD_FWD_EN
    if (bus.fwd_rs1 !== 2'd1) begin n_err++; $display("FAIL fwd_young const got %0d want 1", bus.fwd_rs1); end
    n_vec++;
`endif
    run_until_issue("fwd_young");
  endtask

  task automatic test_load_use();
    int nstall = 0;
    bit was;
    logic [1:0] fwd_at_issue = 2'd3;
    do_reset();
    apply(1, 0, 0, 0, 0, 5'd3, 1, 1, 0, 0); tick();
    apply(1, 5'd3, 1, 5'd0, 0, 5'd0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.stall_id !== e_stall || bus.fwd_rs1 !== e_fwd1) begin
        n_err++; $display("FAIL ldu cyc%0d stall/fwd got %b/%0d want %b/%0d", i, bus.stall_id, bus.fwd_rs1, e_stall, e_fwd1); end
      n_vec++;
      if (bus.stall_id) nstall++;
      was = e_issue;
      if (was) fwd_at_issue = bus.fwd_rs1;
      tick();
      if (was) break;
    end
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
`ifdef HAZARD_FWD_EN
    if (nstall != 1 || fwd_at_issue !== 2'd2 || bus.stall_cnt !== 16'd1) begin
      n_err++; $display("FAIL ldu stalls=%0d fwd=%0d cnt=%0d want 1 2 1", nstall, fwd_at_issue, bus.stall_cnt); end
`else
    if (nstall != 2 || fwd_at_issue !== 2'd0 || bus.stall_cnt !== 16'd2) begin
      n_err++; $display("FAIL ldu stalls=%0d fwd=%0d cnt=%0d want 2 0 2", nstall, fwd_at_issue, bus.stall_cnt); end
`endif
    n_vec++;
  endtask

  task automatic test_flush_hold();
    do_reset();
    apply(1, 0, 0, 0, 0, 5'd9, 1, 0, 0, 0); tick();
    apply(1, 5'd1, 1, 5'd2, 0, 5'd10, 1, 0, 1, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.stall_id !== 1'b1 || bus.bubble_ex !== 1'b0 || bus.stall_cnt !== 16'd0) begin
        n_err++; $display("FAIL flush_hold cyc%0d stall/bubble/cnt got %b%b/%0d want 10/0", i, bus.stall_id, bus.bubble_ex, bus.stall_cnt); end
      n_vec++;
      tick();
      bus.flush = 1'b0; model_eval();
    end
    bus.hold = 1'b0; model_eval();
    @(negedge clk);
    if (bus.bubble_ex !== 1'b1 || bus.stall_id !== 1'b0) begin
      n_err++; $display("FAIL flush_release bubble/stall got %b%b want 10", bus.bubble_ex, bus.stall_id); end
    n_vec++;
    tick();
    apply(1, 5'd10, 1, 5'd0, 0, 5'd0, 0, 0, 0, 0);
    @(negedge clk);
    if (bus.stall_id !== 1'b0 || bus.fwd_rs1 !== 2'd0 || bus.bubble_ex !== 1'b0) begin
      n_err++; $display("FAIL flush_killed stall/fwd/bubble got %b/%0d/%b want 0/0/0", bus.stall_id, bus.fwd_rs1, bus.bubble_ex); end
    n_vec++;
    tick();
  endtask

  task automatic test_x0_unused();
    do_reset();
    apply(1, 0, 0, 0, 0, 5'd0, 1, 1, 0, 0); tick();
    apply(1, 5'd0, 1, 5'd0, 1, 5'd4, 1, 0, 0, 0);
    @(negedge clk);
    if (bus.stall_id !== 1'b0 || {bus.fwd_rs1, bus.fwd_rs2} !== 4'd0) begin
      n_err++; $display("FAIL x0 stall=%b fwd=%0d/%0d want 0 0/0", bus.stall_id, bus.fwd_rs1, bus.fwd_rs2); end
    n_vec++;
    tick();
    apply(1, 5'd0, 1, 5'd4, 0, 5'd0, 0, 0, 0, 0);
    @(negedge clk);
    if (bus.stall_id !== 1'b0 || bus.fwd_rs2 !== 2'd0) begin
      n_err++; $display("FAIL unused_rs2 stall=%b fwd=%0d want 0 0", bus.stall_id, bus.fwd_rs2); end
    n_vec++;
    tick();
  endtask

  task automatic test_saturation_reset();
    do_reset();
    for (int i = 0; i < 8 && m_cnt < 5; i++) begin
      apply(1, 0, 0, 0, 0, 5'd5, 1, 1, 0, 0);
      run_until_issue("sat_prod");
      apply(1, 5'd5, 1, 5'd0, 0, 5'd0, 0, 0, 0, 0);
      run_until_issue("sat_use");
    end
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    if (bus_s.stall_cnt !== 2'd3) begin n_err++; $display("FAIL sat small cnt got %0d want 3", bus_s.stall_cnt); end
    n_vec++;
    if (int'(bus.stall_cnt) != m_cnt || m_cnt < 5) begin
      n_err++; $display("FAIL sat main cnt got %0d want %0d (>=5)", bus.stall_cnt, m_cnt); end
    n_vec++;
    apply(1, 0, 0, 0, 0, 5'd8, 1, 1, 0, 0); tick();
    apply(1, 5'd8, 1, 5'd0, 0, 5'd0, 0, 0, 0, 0);
    @(negedge clk);
    if (bus.stall_id !== 1'b1) begin n_err++; $display("FAIL rst_mid pre stall got %b want 1", bus.stall_id); end
    n_vec++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    if ({bus.stall_if, bus.stall_id, bus.bubble_ex, bus.fwd_rs1, bus.fwd_rs2} !== 7'd0 ||
        bus.stall_cnt !== 16'd0 || bus_s.stall_cnt !== 2'd0) begin
      n_err++; $display("FAIL rst_mid ctrl=%b fwd=%0d/%0d cnt=%0d/%0d want all 0", {bus.stall_if, bus.stall_id, bus.bubble_ex},
                        bus.fwd_rs1, bus.fwd_rs2, bus.stall_cnt, bus_s.stall_cnt); end
    n_vec++;
    tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      apply($urandom_range(0, 99) < 85, 5'($urandom_range(0, 7)), 1'($urandom), 5'($urandom_range(0, 7)),
            1'($urandom), 5'($urandom_range(0, 7)), $urandom_range(0, 99) < 70, 1'($urandom),
            $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 15);
      @(negedge clk);
      if (bus.stall_if !== e_stall || bus.stall_id !== e_stall || bus.bubble_ex !== e_bubble) begin
        n_err++; $display("FAIL rnd%0d ctrl got %b%b%b want %b%b%b", i, bus.stall_if, bus.stall_id, bus.bubble_ex, e_stall, e_stall, e_bubble); end
      n_vec++;
      if (bus.fwd_rs1 !== e_fwd1 || bus.fwd_rs2 !== e_fwd2) begin
        n_err++; $display("FAIL rnd%0d fwd got %0d/%0d want %0d/%0d", i, bus.fwd_rs1, bus.fwd_rs2, e_fwd1, e_fwd2); end
      n_vec++;
      if (int'(bus.stall_cnt) != sat(m_cnt, 65535) || int'(bus_s.stall_cnt) != sat(m_cnt, 3)) begin
        n_err++; $display("FAIL rnd%0d cnt got %0d/%0d want %0d/%0d", i, bus.stall_cnt, bus_s.stall_cnt, sat(m_cnt, 65535), sat(m_cnt, 3)); end
      n_vec++;
      tick();
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_raw_stall();
    test_forwarding();
    test_load_use();
    test_flush_hold();
    test_x0_unused();
    test_saturation_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
